ntt_job_arbiter: RTL and testbench
==================================

Name: ntt_job_arbiter

Overview:
Round-robin scheduler that shares one pipelined 8-point transform engine (forward NTT / inverse NTT, q = 3329) between two requesters. It accepts jobs over ready/valid channels and drives the engine's valid/coefficient/mode inputs. It tags every in-flight job and buffers engine results, then returns each result in order to the requester that issued it. Output buffer credits ensure the non-stallable engine never produces a result with nowhere to store it.

Parameters:
BUF_DEPTH, 4, maximum jobs outstanding: issued but not yet returned on a response channel (power of 2, 2..16)
ENGINE_LAT, 3, engine latency in cycles from eng_valid_in to eng_valid_out; used only by assertions and the bench model

Ports:
clk  in  1  clock, rising edge
r  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 job valid
req0_ready  out  1  requester 0 job accepted this cycle
req0_inverse  in  1  requester 0 mode: 1 = iNTT, 0 = NTT
req0_coeffs  in  12x8  requester 0 coefficients [11:0] [7:0]
req1_valid / req1_ready / req1_inverse / req1_coeffs  same as requester 0, for requester 1
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 takes the result
rsp1_valid / rsp1_ready  same as rsp0, for requester 1
rsp_coeffs  out  12x8  head-of-buffer result, shared by both response channels
eng_valid_in  out  1  engine input valid (registered)
eng_inverse  out  1  engine mode (registered)
eng_coeffs  out  12x8  engine input coefficients (registered)
eng_valid_out  in  1  engine result valid
eng_coeffs_out  in  12x8  engine result
drain  in  1  level; stop granting new jobs
idle  out  1  occupancy == 0 and no grant pending
err  out  1  sticky: eng_valid_out seen with no tag outstanding

Behaviour:
- Reset (r == 0 at a clk edge):
  - all outputs 0; occupancy 0; both FIFOs empty; rr pointer = 1 (requester 0 wins the first tie); state RUN; err cleared.
  - idle reads 1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight tags and buffered results. The engine shares clk and r.
- Occupancy counter occ (0..BUF_DEPTH):
  - +1 on a request handshake.
  - -1 on a response handshake.
  - Both in the same cycle: unchanged.
- Grant (combinational, RUN only, occ < BUF_DEPTH):
  - one valid: grant it.
  - both valid: grant the requester not granted last.
  - reqN_ready = grant for N. The rr pointer updates only on a handshake.
  - At most one grant per cycle.
  - No grant while occ == BUF_DEPTH, which guarantees the result buffer never overflows.
- Issue pipeline:
  - On a handshake at cycle t, eng_coeffs / eng_inverse latch the granted requester's data.
  - eng_valid_in = 1 for exactly cycle t+1.
  - The granted requester ID is pushed into the tag FIFO (depth BUF_DEPTH).
  - Back-to-back jobs issue every cycle.
- Result capture, on eng_valid_out = 1:
  - pop the tag FIFO;
  - push {tag, eng_coeffs_out} into the result FIFO (depth BUF_DEPTH);
  - a push and a pop of the result FIFO in the same cycle are both honoured.
- Empty tag FIFO at eng_valid_out: err <= 1 (sticky until reset), result dropped, occ unaffected.
- Response:
  - rspN_valid = result FIFO non-empty and head tag == N. The other channel's valid is 0.
  - rsp_coeffs = head data.
  - Pop on rspN_valid & rspN_ready.
  - Strict in-order return: a stalled requester blocks the other requester's later results (head-of-line). This is intentional and keeps the buffer a simple FIFO.
- Latency: request handshake at t -> eng_valid_in at t+1 -> result captured at t+1+ENGINE_LAT -> rspN_valid high at t+2+ENGINE_LAT.
- FSM:
  - RUN: grants as above. drain == 1 -> DRAIN.
  - DRAIN: no grants; in-flight jobs and responses continue. When occ == 0 and drain == 0 -> RUN. While drain stays 1, remain in DRAIN with idle = 1.
  - drain asserted in the same cycle as a would-be grant: the grant is suppressed.
- idle = (occ == 0) & ~eng_valid_in.

Test Plan:
- Single job: req0_valid with coeffs {1,2,3,4,5,6,7,8}, inverse = 0 -> req0_ready at t; eng_valid_in at t+1 with same coeffs and eng_inverse = 0; rsp0_valid at t+2+ENGINE_LAT carrying the engine-model result; rsp1_valid stays 0; idle returns to 1 after the pop.
- Contention: req0 and req1 both valid for 6 cycles -> grants alternate 0,1,0,1,…; results return in that order on the matching channel; no overflow.
- Credit limit: rsp0_ready = 0, BUF_DEPTH = 4, req0 continuously valid -> exactly 4 handshakes, then req0_ready = 0. Raise rsp0_ready -> one new grant per freed slot; occ never exceeds 4.
- Head-of-line: job A (req0) then job B (req1); hold rsp0_ready = 0 for 10 cycles -> rsp1_valid stays 0 until A pops, then B is presented.
- Drain: assert drain with 2 jobs in flight -> no further req*_ready; both results still returned; idle = 1. Deassert drain -> granting resumes next cycle.
- Error / reset:
  - Inject eng_valid_out with no outstanding job -> err = 1 and stays 1.
  - Pull r low with 3 jobs outstanding -> next cycle all valids 0, idle = 1, err = 0.
  - A new job then completes normally.

Source files
------------

// File: rtl/ntt_job_arbiter.sv
// Round-robin job scheduler in front of a shared, non-stallable 8-point NTT/iNTT engine.
// Tags each issued job, buffers engine results and returns them in issue order to their requester.
module ntt_job_arbiter #(
    parameter int BUF_DEPTH  = 4,
    parameter int ENGINE_LAT = 3
) (
    input  logic        clk,
    input  logic        r,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_inverse,
    input  logic [95:0] req0_coeffs,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_inverse,
    input  logic [95:0] req1_coeffs,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [95:0] rsp_coeffs,
    output logic        eng_valid_in,
    output logic        eng_inverse,
    output logic [95:0] eng_coeffs,
    input  logic        eng_valid_out,
    input  logic [95:0] eng_coeffs_out,
    input  logic        drain,
    output logic        idle,
    output logic        err,
    output logic        state_dbg
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(BUF_DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t        state;
    logic [AW:0]   occ;
    logic          last_gnt;
    logic          gnt0, gnt1;
    logic          req_hs, rsp_hs;

    logic          tag_mem [BUF_DEPTH];
    logic [AW-1:0] tag_wr, tag_rd;
    logic [AW:0]   tag_cnt;
    logic          tag_empty, cap;

    logic          res_tag  [BUF_DEPTH];
    logic [95:0]   res_data [BUF_DEPTH];
    logic [AW-1:0] res_wr, res_rd;
    logic [AW:0]   res_cnt;
    logic          res_nonempty;

    // Every channel transfers on a cycle where valid and ready are both high; valid never
    // depends on ready, and a source holds valid and data stable until the transfer happens.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == ST_RUN && !drain && occ < DEPTH_C) begin
            if (req0_valid && req1_valid) begin
                if (last_gnt) gnt0 = 1'b1;
                else          gnt1 = 1'b1;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready   = gnt0;
    assign req1_ready   = gnt1;
    assign req_hs       = gnt0 | gnt1;

    assign res_nonempty = (res_cnt != '0);
    assign rsp0_valid   = res_nonempty & ~res_tag[res_rd];
    assign rsp1_valid   = res_nonempty &  res_tag[res_rd];
    assign rsp_coeffs   = res_nonempty ? res_data[res_rd] : '0;
    assign rsp_hs       = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

    assign tag_empty    = (tag_cnt == '0);
    assign cap          = eng_valid_out & ~tag_empty;

    assign idle         = (occ == '0) & ~eng_valid_in;
    assign state_dbg    = (state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (!r) begin
            state        <= ST_RUN;
            occ          <= '0;
            last_gnt     <= 1'b1;
            eng_valid_in <= 1'b0;
            eng_inverse  <= 1'b0;
            eng_coeffs   <= '0;
            tag_wr       <= '0;
            tag_rd       <= '0;
            tag_cnt      <= '0;
            res_wr       <= '0;
            res_rd       <= '0;
            res_cnt      <= '0;
            err          <= 1'b0;
        end else begin
            case (state)
                ST_RUN:   if (drain) state <= ST_DRAIN;
                ST_DRAIN: if (occ == '0 && !drain) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase

            if (req_hs && !rsp_hs)      occ <= occ + CNT_ONE;
            else if (!req_hs && rsp_hs) occ <= occ - CNT_ONE;

            if (req_hs) last_gnt <= gnt1;

            eng_valid_in <= req_hs;
            if (req_hs) begin
                eng_inverse <= gnt1 ? req1_inverse : req0_inverse;
                eng_coeffs  <= gnt1 ? req1_coeffs  : req0_coeffs;
            end

            if (req_hs) tag_wr <= tag_wr + PTR_ONE;
            if (cap)    tag_rd <= tag_rd + PTR_ONE;
            if (req_hs && !cap)      tag_cnt <= tag_cnt + CNT_ONE;
            else if (!req_hs && cap) tag_cnt <= tag_cnt - CNT_ONE;

            // A result with no matching tag has no owner: drop it and flag the fault.
            if (eng_valid_out && tag_empty) err <= 1'b1;

            if (cap)    res_wr <= res_wr + PTR_ONE;
            if (rsp_hs) res_rd <= res_rd + PTR_ONE;
            if (cap && !rsp_hs)      res_cnt <= res_cnt + CNT_ONE;
            else if (!cap && rsp_hs) res_cnt <= res_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (req_hs) tag_mem[tag_wr] <= gnt1;
        if (cap) begin
            res_tag[res_wr]  <= tag_mem[tag_rd];
            res_data[res_wr] <= eng_coeffs_out;
        end
    end

    // Tracks when each issued job should come back out of the engine.
    logic [ENGINE_LAT-1:0] lat_sr;

    always_ff @(posedge clk) begin
        if (!r) lat_sr <= '0;
        else    lat_sr <= (lat_sr << 1) | ENGINE_LAT'(eng_valid_in);
    end

    always_ff @(posedge clk) begin
        if (r) begin
            assert (occ <= DEPTH_C);
            assert (!lat_sr[ENGINE_LAT-1] || eng_valid_out);
        end
    end

endmodule

// File: tb/tb_ntt_job_arbiter.sv
// Bench for ntt_job_arbiter: pipelined NTT engine stub, transaction-level reference model
// compared every cycle, and directed scenarios with hand-computed expectations.
module tb_ntt_job_arbiter;

    localparam int DEPTH = 4;
    localparam int LAT   = 3;
    localparam int Q     = 3329;

    logic        clk = 1'b0;
    logic        r;
    logic        req0_valid, req0_ready, req0_inverse;
    logic [95:0] req0_coeffs;
    logic        req1_valid, req1_ready, req1_inverse;
    logic [95:0] req1_coeffs;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [95:0] rsp_coeffs;
    logic        eng_valid_in, eng_inverse;
    logic [95:0] eng_coeffs;
    logic        eng_valid_out;
    logic [95:0] eng_coeffs_out;
    logic        drain, idle, err, state_dbg;
    logic        inj;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    ntt_job_arbiter #(.BUF_DEPTH(DEPTH), .ENGINE_LAT(LAT)) dut (
        .clk(clk), .r(r),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_inverse(req0_inverse), .req0_coeffs(req0_coeffs),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_inverse(req1_inverse), .req1_coeffs(req1_coeffs),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_coeffs(rsp_coeffs),
        .eng_valid_in(eng_valid_in), .eng_inverse(eng_inverse), .eng_coeffs(eng_coeffs),
        .eng_valid_out(eng_valid_out), .eng_coeffs_out(eng_coeffs_out),
        .drain(drain), .idle(idle), .err(err), .state_dbg(state_dbg)
    );

    function automatic logic [95:0] mk(int a0, int a1, int a2, int a3,
                                       int a4, int a5, int a6, int a7);
        return {12'(a7), 12'(a6), 12'(a5), 12'(a4), 12'(a3), 12'(a2), 12'(a1), 12'(a0)};
    endfunction

    // Plain O(n^2) 8-point transform mod q with w = 17^32, a primitive 8th root of unity.
    function automatic logic [95:0] ntt8(input logic [95:0] c, input logic inv);
        int p[8];
        int root, base, acc;
        logic [95:0] o;
        root = 1;
        for (int i = 0; i < 32; i++) root = (root * 17) % Q;
        if (inv) begin
            base = root;
            for (int i = 0; i < 6; i++) root = (root * base) % Q;
        end
        p[0] = 1;
        for (int i = 1; i < 8; i++) p[i] = (p[i-1] * root) % Q;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            acc = 0;
            for (int j = 0; j < 8; j++) acc = (acc + int'(c[12*j +: 12]) * p[(i*j) % 8]) % Q;
            if (inv) acc = (acc * 2913) % Q;
            o[12*i +: 12] = acc[11:0];
        end
        return o;
    endfunction

    // Engine stub: fixed-latency pipeline sharing clk and r with the arbiter.
    logic [2:0]  pv;
    logic [95:0] pd [3];

    always @(posedge clk) begin
        if (!r) begin
            pv <= '0;
        end else begin
            pv    <= {pv[1:0], eng_valid_in};
            pd[0] <= ntt8(eng_coeffs, eng_inverse);
            pd[1] <= pd[0];
            pd[2] <= pd[1];
        end
    end

    assign eng_valid_out  = pv[2] | inj;
    assign eng_coeffs_out = pd[2];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: jobs in flight as {requester, expected result} plus acceptance cycle.
    logic [96:0] exp_q [$];
    int          acc_q [$];
    int          cyc;
    bit          mvalid = 0;
    bit          m_last, m_drain, m_engv, m_err;
    logic        m_engi;
    logic [95:0] m_engc;
    bit          e_g0, e_g1, e_hv, e_r0, e_r1, found;
    int          sz;

    always @(negedge clk) begin
        sz   = exp_q.size();
        e_hv = (sz > 0) ? (cyc >= acc_q[0] + 2 + LAT) : 1'b0;
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (e_hv) begin
            e_r0 = ~exp_q[0][96];
            e_r1 =  exp_q[0][96];
        end
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (!m_drain && !drain && sz < DEPTH) begin
            if (req0_valid && req1_valid) begin
                if (m_last) e_g0 = 1'b1;
                else        e_g1 = 1'b1;
            end else if (req0_valid) e_g0 = 1'b1;
            else if (req1_valid)     e_g1 = 1'b1;
        end

        if (mvalid) begin
            chk("req0_ready", req0_ready, e_g0);
            chk("req1_ready", req1_ready, e_g1);
            chk("rsp0_valid", rsp0_valid, e_r0);
            chk("rsp1_valid", rsp1_valid, e_r1);
            chk("eng_valid_in", eng_valid_in, m_engv);
            chk("idle", idle, (sz == 0) && !m_engv);
            chk("err", err, m_err);
            chk("state_dbg", state_dbg, m_drain);
            if (m_engv) begin
                chk("eng_coeffs", eng_coeffs, m_engc);
                chk("eng_inverse", eng_inverse, m_engi);
            end
            if (e_hv) chk("rsp_coeffs", rsp_coeffs, exp_q[0][95:0]);
        end

        if (!r) begin
            exp_q.delete();
            acc_q.delete();
            cyc     = 0;
            m_last  = 1'b1;
            m_drain = 1'b0;
            m_engv  = 1'b0;
            m_err   = 1'b0;
            mvalid  = 1'b1;
        end else if (mvalid) begin
            found = 1'b0;
            foreach (acc_q[i]) if (acc_q[i] < cyc && cyc <= acc_q[i] + 1 + LAT) found = 1'b1;
            if (inj && !found) m_err = 1'b1;
            if (!m_drain && drain) m_drain = 1'b1;
            else if (m_drain && sz == 0 && !drain) m_drain = 1'b0;
            if ((e_r0 && rsp0_ready) || (e_r1 && rsp1_ready)) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            m_engv = e_g0 | e_g1;
            if (e_g0) begin
                exp_q.push_back({1'b0, ntt8(req0_coeffs, req0_inverse)});
                acc_q.push_back(cyc);
                m_last = 1'b0;
                m_engc = req0_coeffs;
                m_engi = req0_inverse;
            end
            if (e_g1) begin
                exp_q.push_back({1'b1, ntt8(req1_coeffs, req1_inverse)});
                acc_q.push_back(cyc);
                m_last = 1'b1;
                m_engc = req1_coeffs;
                m_engi = req1_inverse;
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input logic inv, input logic [95:0] c);
        bit got = 1'b0;
        if (n == 0) begin req0_valid = 1'b1; req0_inverse = inv; req0_coeffs = c; end
        else        begin req1_valid = 1'b1; req1_inverse = inv; req1_coeffs = c; end
        for (int k = 0; k < 40 && !got; k++) begin
            #1;
            got = (n == 0) ? req0_ready : req1_ready;
            step();
        end
        if (n == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
        chk("send_handshake", got, 1'b1);
    endtask

    task automatic wait_rsp(input int n);
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            got = (n == 0) ? rsp0_valid : rsp1_valid;
            if (!got) step();
        end
        chk("wait_rsp", got, 1'b1);
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin
            got = idle;
            if (!got) step();
        end
        chk("wait_idle", got, 1'b1);
    endtask

    initial begin
        #100000;
        n_miss++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order [6];
        int nh, gr, cnt;

        r = 1'b0; inj = 1'b0; drain = 1'b0;
        req0_valid = 1'b0; req0_inverse = 1'b0; req0_coeffs = '0;
        req1_valid = 1'b0; req1_inverse = 1'b0; req1_coeffs = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (3) step();
        r = 1'b1;
        step();
        chk("rst_idle", idle, 1'b1);
        chk("rst_err", err, 1'b0);
        chk("rst_eng_valid", eng_valid_in, 1'b0);
        chk("rst_rsp0", rsp0_valid, 1'b0);

        // Single job with exact latency and literal transform values.
        req0_coeffs = mk(1, 2, 3, 4, 5, 6, 7, 8);
        req0_inverse = 1'b0;
        req0_valid = 1'b1;
        #1;
        chk("single_ready", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        chk("single_eng_v", eng_valid_in, 1'b1);
        chk("single_eng_c", eng_coeffs, mk(1, 2, 3, 4, 5, 6, 7, 8));
        chk("single_eng_i", eng_inverse, 1'b0);
        repeat (LAT) step();
        chk("single_rsp_early", rsp0_valid, 1'b0);
        step();
        chk("single_rsp0", rsp0_valid, 1'b1);
        chk("single_rsp1", rsp1_valid, 1'b0);
        chk("single_lane0", rsp_coeffs[11:0], 12'd36);
        chk("single_lane4", rsp_coeffs[59:48], 12'd3325);
        step();
        chk("single_idle", idle, 1'b1);

        // Impulse inputs: easy-to-derive outputs for both modes.
        send(0, 1'b1, mk(8, 0, 0, 0, 0, 0, 0, 0));
        wait_rsp(0);
        chk("pin_inverse", rsp_coeffs, mk(1, 1, 1, 1, 1, 1, 1, 1));
        step();
        send(1, 1'b0, mk(5, 0, 0, 0, 0, 0, 0, 0));
        wait_rsp(1);
        chk("pin_forward", rsp_coeffs, mk(5, 5, 5, 5, 5, 5, 5, 5));
        step();
        wait_idle();

        // Contention: both requesters always valid; grants must alternate starting with 0.
        req0_coeffs = mk(10, 20, 30, 40, 50, 60, 70, 80);
        req1_coeffs = mk(9, 8, 7, 6, 5, 4, 3, 2);
        req1_inverse = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        nh = 0;
        for (int k = 0; k < 40 && nh < 6; k++) begin
            gr = -1;
            #1;
            if (req0_ready) gr = 0;
            else if (req1_ready) gr = 1;
            step();
            if (gr >= 0) begin
                order[nh] = gr;
                nh++;
                if (gr == 0) req0_coeffs = mk(nh, 2*nh, 3*nh, 4*nh, 5, 6, 7, 100 + nh);
                else         req1_coeffs = mk(200 + nh, nh, 0, 3, nh, 9, 1, 2);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req1_inverse = 1'b0;
        chk("cont_count", nh, 6);
        for (int i = 0; i < 6; i++) chk("cont_order", order[i], i % 2);
        wait_idle();

        // Credit limit: nothing drains, so exactly DEPTH jobs are accepted.
        rsp0_ready = 1'b0;
        req0_coeffs = mk(3, 1, 4, 1, 5, 9, 2, 6);
        req0_valid = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (req0_ready) cnt++;
            step();
        end
        chk("credit_handshakes", cnt, 4);
        #1;
        chk("credit_ready_low", req0_ready, 1'b0);
        rsp0_ready = 1'b1;
        repeat (8) step();
        req0_valid = 1'b0;
        wait_idle();

        // Head-of-line: requester 1's result waits behind a stalled requester 0.
        rsp0_ready = 1'b0;
        send(0, 1'b0, mk(7, 7, 7, 7, 1, 1, 1, 1));
        send(1, 1'b1, mk(2, 4, 6, 8, 10, 12, 14, 16));
        for (int k = 0; k < 10; k++) begin
            chk("hol_rsp1_blocked", rsp1_valid, 1'b0);
            step();
        end
        rsp0_ready = 1'b1;
        wait_rsp(0);
        step();
        chk("hol_b_present", rsp1_valid, 1'b1);
        wait_idle();

        // Drain with two jobs in flight.
        send(0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 1));
        send(1, 1'b0, mk(0, 1, 0, 0, 0, 0, 1, 0));
        drain = 1'b1;
        req0_coeffs = mk(4, 4, 4, 4, 0, 0, 0, 0);
        req0_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("drain_no_grant", req0_ready, 1'b0);
            step();
        end
        chk("drain_idle", idle, 1'b1);
        chk("drain_state", state_dbg, 1'b1);
        drain = 1'b0;
        #1;
        chk("drain_exit_wait", req0_ready, 1'b0);
        step();
        #1;
        chk("drain_resume", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        wait_idle();

        // Spurious engine result.
        repeat (6) step();
        inj = 1'b1;
        step();
        inj = 1'b0;
        chk("err_set", err, 1'b1);
        repeat (3) step();
        chk("err_sticky", err, 1'b1);
        chk("err_idle", idle, 1'b1);

        // Reset with three jobs outstanding, then a normal job.
        rsp0_ready = 1'b0;
        send(0, 1'b0, mk(1, 1, 1, 1, 1, 1, 1, 1));
        send(0, 1'b1, mk(2, 2, 2, 2, 2, 2, 2, 2));
        send(0, 1'b0, mk(3, 3, 3, 3, 3, 3, 3, 3));
        r = 1'b0;
        step();
        chk("rst_mid_rsp0", rsp0_valid, 1'b0);
        chk("rst_mid_rsp1", rsp1_valid, 1'b0);
        chk("rst_mid_eng_v", eng_valid_in, 1'b0);
        chk("rst_mid_idle", idle, 1'b1);
        chk("rst_mid_err", err, 1'b0);
        r = 1'b1;
        rsp0_ready = 1'b1;
        step();
        send(1, 1'b0, mk(5, 0, 0, 0, 0, 0, 0, 0));
        wait_rsp(1);
        chk("post_rst_result", rsp_coeffs, mk(5, 5, 5, 5, 5, 5, 5, 5));
        step();
        wait_idle();

        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
